// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: FSM states, response codes and broadcast channel for the frame loader
package uart_frame_pkg;
    typedef enum logic [2:0] {HDR, PAYLOAD, CSUM, COMMIT, RESP} frame_state_t;
    localparam logic [7:0] RSP_ACK         = 8'h06;
    localparam logic [7:0] RSP_NAK_CSUM    = 8'h15;
    localparam logic [7:0] RSP_NAK_CHAN    = 8'h16;
    localparam logic [7:0] RSP_NAK_LEN     = 8'h17;
    localparam logic [7:0] RSP_NAK_TIMEOUT = 8'h18;
    localparam logic [7:0] BROADCAST_CHAN  = 8'hFF;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs dequeued bytes MSB first into 32-bit words
module byte_word_packer
    import uart_frame_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_partial
);
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;
    // keep the last three bytes and count toward a full word; clear drops a partial word
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (i_valid) begin
            shift_q <= {shift_q[15:0], i_byte};
            cnt_q   <= cnt_q + 2'd1;
        end
    end
    assign o_word       = {shift_q, i_byte};
    assign o_word_valid = i_valid && cnt_q == 2'd3;
    assign o_partial    = cnt_q != 2'd0;
endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: parses framed register images from the UART RX queue and commits them to channel banks
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int          NUM_CHANNELS   = 24,
    parameter int          FRAME_WORDS    = 62,
    parameter logic [15:0] MAGIC          = 16'hD5C0,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic [7:0]                                   i_rxq_data,
    input  logic                                         i_rxq_empty,
    output logic                                         o_deq_rxq,
    output logic [7:0]                                   o_txq_data,
    output logic                                         o_enq_txq,
    input  logic                                         i_txq_full,
    output logic [NUM_CHANNELS-1:0][FRAME_WORDS-1:0][31:0] o_regs,
    output logic                                         o_commit,
    output logic [7:0]                                   o_commit_chan,
    output logic                                         o_busy
);
    localparam int         GW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [8:0] NCH = 9'(NUM_CHANNELS);
    localparam logic [8:0] NFW = 9'(FRAME_WORDS);

    frame_state_t  state_q, state_d;
    logic [7:0]    rsp_q, rsp_d, chan_q, chan_d, len_q, len_d, idx_q, idx_d;
    logic [31:0]   xor_q, xor_d, word;
    logic [31:0]   stage_q [FRAME_WORDS];
    logic [GW-1:0] gap_q;
    logic          word_valid, partial, in_frame, busy, deq, counting, timeout, chan_ok, len_ok;

    assign in_frame = state_q inside {HDR, PAYLOAD, CSUM};
    assign deq      = !i_rst && !i_rxq_empty && in_frame;
    assign busy     = state_q != HDR || partial;
    assign counting = busy && in_frame && !deq;
    assign timeout  = counting && gap_q == GW'(TIMEOUT_CYCLES - 1);
    assign chan_ok  = {1'b0, word[15:8]} < NCH || word[15:8] == BROADCAST_CHAN;
    assign len_ok   = word[7:0] != 8'd0 && {1'b0, word[7:0]} <= NFW;

    byte_word_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (timeout),
        .i_valid      (deq),
        .i_byte       (i_rxq_data),
        .o_word       (word),
        .o_word_valid (word_valid),
        .o_partial    (partial)
    );

    // frame parser: header checks, payload accumulation, checksum verdict and response hand-off
    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        chan_d  = chan_q;
        len_d   = len_q;
        idx_d   = idx_q;
        xor_d   = xor_q;
        if (timeout) begin
            state_d = RESP;
            rsp_d   = RSP_NAK_TIMEOUT;
        end else begin
            case (state_q)
                HDR: if (word_valid && word[31:16] == MAGIC) begin
                    state_d = chan_ok && len_ok ? PAYLOAD : RESP;
                    rsp_d   = !chan_ok ? RSP_NAK_CHAN : RSP_NAK_LEN;
                    chan_d  = word[15:8];
                    len_d   = word[7:0];
                    idx_d   = '0;
                    xor_d   = word;
                end
                PAYLOAD: if (word_valid) begin
                    xor_d   = xor_q ^ word;
                    idx_d   = idx_q + 8'd1;
                    state_d = idx_q == len_q - 8'd1 ? CSUM : PAYLOAD;
                end
                CSUM: if (word_valid) begin
                    state_d = word == xor_q ? COMMIT : RESP;
                    rsp_d   = RSP_NAK_CSUM;
                end
                COMMIT: begin
                    state_d = RESP;
                    rsp_d   = RSP_ACK;
                end
                RESP: state_d = i_txq_full ? RESP : HDR;
                default: state_d = HDR;
            endcase
        end
    end

    // parser state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= HDR;
            rsp_q   <= '0;
            chan_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            xor_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            chan_q  <= chan_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            xor_q   <= xor_d;
        end
    end

    // idle-gap counter: runs only while a frame is open and nothing is dequeued
    always_ff @(posedge i_clk) begin
        if (i_rst || !counting)
            gap_q <= '0;
        else
            gap_q <= gap_q + GW'(1);
    end

    // staging buffer collects payload words so the banks only change on a full, verified frame
    always_ff @(posedge i_clk) begin
        for (int w = 0; w < FRAME_WORDS; w++)
            if (i_rst)
                stage_q[w] <= '0;
            else if (state_q == PAYLOAD && word_valid && idx_q == 8'(w))
                stage_q[w] <= word;
    end

    // atomic bank load of words 0..L-1 into the target bank or every bank on broadcast
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_regs <= '0;
        else if (state_q == COMMIT)
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int w = 0; w < FRAME_WORDS; w++)
                    if (8'(w) < len_q && (chan_q == BROADCAST_CHAN || chan_q == 8'(c)))
                        o_regs[c][w] <= stage_q[w];
    end

    assign o_deq_rxq     = deq;
    assign o_enq_txq     = !i_rst && state_q == RESP && !i_txq_full;
    assign o_txq_data    = state_q == RESP ? rsp_q : 8'h00;
    assign o_commit      = !i_rst && state_q == COMMIT;
    assign o_commit_chan = o_commit ? chan_q : 8'h00;
    assign o_busy        = !i_rst && busy;
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: randomized frame traffic checked against a bank-level reference model
module tb_uart_frame_loader;
    localparam int          NCH   = 24;
    localparam int          FW    = 62;
    localparam int          TO    = 40;
    localparam logic [15:0] MAGIC = 16'hD5C0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rxq_data = 8'h00;
    logic rxq_empty = 1'b1;
    logic txq_full = 1'b0;
    logic deq, enq, commit, busy;
    logic [7:0] txq_data, commit_chan;
    logic [NCH-1:0][FW-1:0][31:0] regs;

    uart_frame_loader #(
        .NUM_CHANNELS(NCH), .FRAME_WORDS(FW), .MAGIC(MAGIC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_rxq_data(rxq_data), .i_rxq_empty(rxq_empty),
        .o_deq_rxq(deq), .o_txq_data(txq_data), .o_enq_txq(enq), .i_txq_full(txq_full),
        .o_regs(regs), .o_commit(commit), .o_commit_chan(commit_chan), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0, last_deq_cyc = 0, commit_cyc = 0, enq_cyc = 0, stall_deq = 0;
    bit stalling = 0;
    logic [7:0]  rxq [$];
    logic [7:0]  txq [$];
    logic [7:0]  cq [$];
    logic [31:0] mdl [NCH][FW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        rxq_empty = rxq.size() == 0;
        rxq_data  = rxq.size() > 0 ? rxq[0] : 8'h00;
    endtask

    // one clock: sample outputs on the falling edge, retire consumed bytes after the rising edge
    task automatic step();
        bit d;
        @(negedge clk);
        cyc++;
        d = deq;
        if (deq) last_deq_cyc = cyc;
        if (deq && stalling) stall_deq++;
        if (enq) begin txq.push_back(txq_data); enq_cyc = cyc; end
        if (commit) begin cq.push_back(commit_chan); commit_cyc = cyc; end
        @(posedge clk);
        #1;
        if (d && rxq.size() > 0) void'(rxq.pop_front());
        refresh();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) rxq.push_back(w[8*i +: 8]);
        refresh();
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 3 * TO + 400 && txq.size() < n; i++) step();
        check("tx_arrived", txq.size() >= n, 1);
    endtask

    function automatic int regs_diff();
        int d = 0;
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < FW; w++)
                if (regs[c][w] !== mdl[c][w]) d++;
        return d;
    endfunction

    // queue one frame's bytes and apply its effect to the model; returns the expected response
    task automatic load_frame(input logic [7:0] ch, input logic [7:0] len, input bit bad, output logic [7:0] exp);
        logic [31:0] x, w;
        logic [31:0] pl [$];
        bit ok_ch, ok_len;
        ok_ch  = int'(ch) < NCH || ch == 8'hFF;
        ok_len = len >= 8'd1 && int'(len) <= FW;
        exp = !ok_ch ? 8'h16 : !ok_len ? 8'h17 : bad ? 8'h15 : 8'h06;
        x = {MAGIC, ch, len};
        push_word(x);
        if (ok_ch && ok_len) begin
            for (int k = 0; k < int'(len); k++) begin
                w = $urandom;
                pl.push_back(w);
                x ^= w;
                push_word(w);
            end
            push_word(bad ? x ^ 32'h1 : x);
            if (!bad)
                for (int c = 0; c < NCH; c++)
                    if (ch == 8'hFF || int'(ch) == c)
                        for (int k = 0; k < int'(len); k++) mdl[c][k] = pl[k];
        end
    endtask

    task automatic run_frame(input logic [7:0] ch, input logic [7:0] len, input bit bad);
        logic [7:0] exp;
        txq.delete();
        cq.delete();
        load_frame(ch, len, bad, exp);
        wait_tx(1);
        check("rsp", txq.size() > 0 ? txq[0] : 8'h00, exp);
        check("tx_count", txq.size(), 1);
        check("commit_count", cq.size(), exp == 8'h06);
        if (exp == 8'h06 && cq.size() > 0) begin
            check("commit_chan", cq[0], ch);
            check("commit_lat", commit_cyc - last_deq_cyc, 1);
            check("ack_lat", enq_cyc - commit_cyc, 1);
        end
        check("regs", regs_diff(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ch, len, exp;
        logic [31:0] g;
        int r, d;
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < FW; w++) mdl[c][w] = '0;
        @(posedge clk);
        #1;
        push_word(32'h1234_5678);
        step();
        step();
        check("deq_in_reset", deq, 0);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_enq", enq, 0);
        check("rst_commit", commit, 0);
        check("rst_txdata", txq_data, 0);
        check("rst_chan", commit_chan, 0);
        check("rst_regs", regs_diff(), 0);
        for (int i = 0; i < 8; i++) step();

        run_frame(8'd3, 8'd5, 1'b0);
        run_frame(8'd3, 8'd5, 1'b1);
        run_frame(8'd4, 8'd7, 1'b0);
        run_frame(8'h18, 8'd5, 1'b0);
        run_frame(8'd1, 8'd0, 1'b0);
        run_frame(8'd1, 8'd63, 1'b0);
        for (int i = 0; i < 3; i++) begin
            g = $urandom;
            if (g[31:16] == MAGIC) g ^= 32'h0001_0000;
            push_word(g);
        end
        run_frame(8'd9, 8'd2, 1'b0);
        run_frame(8'hFF, 8'd62, 1'b0);
        run_frame(8'd23, 8'd62, 1'b0);

        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(0, 9);
            ch = r == 0 ? 8'hFF : r == 1 ? 8'($urandom_range(24, 254)) : 8'($urandom_range(0, 23));
            r = $urandom_range(0, 9);
            len = r == 0 ? ($urandom_range(0, 1) == 1 ? 8'd63 : 8'd0) : 8'($urandom_range(1, FW));
            run_frame(ch, len, $urandom_range(0, 4) == 0);
        end

        txq.delete();
        push_word({MAGIC, 8'd1, 8'd3});
        rxq.push_back(8'hAB);
        rxq.push_back(8'hCD);
        refresh();
        wait_tx(1);
        check("timeout_rsp", txq.size() > 0 ? txq[0] : 8'h00, 8'h18);
        d = enq_cyc - last_deq_cyc;
        check("timeout_lat", d >= TO && d <= TO + 2, 1);
        check("timeout_regs", regs_diff(), 0);
        step();
        check("timeout_idle", busy, 0);
        run_frame(8'd1, 8'd3, 1'b0);

        txq.delete();
        cq.delete();
        txq_full = 1'b1;
        load_frame(8'd5, 8'd4, 1'b0, exp);
        load_frame(8'd7, 8'd2, 1'b0, exp);
        for (int i = 0; i < 200 && cq.size() == 0; i++) step();
        check("bp_commit", cq.size(), 1);
        stalling = 1;
        stall_deq = 0;
        for (int i = 0; i < 20; i++) step();
        stalling = 0;
        check("bp_no_deq", stall_deq, 0);
        check("bp_no_enq", txq.size(), 0);
        txq_full = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("bp_one_enq", txq.size(), 1);
        check("bp_rsp", txq.size() > 0 ? txq[0] : 8'h00, 8'h06);
        wait_tx(2);
        check("bp_rsp2", txq.size() > 1 ? txq[1] : 8'h00, 8'h06);
        check("bp_chan2", cq.size() > 1 ? cq[1] : 8'h00, 8'd7);
        check("bp_regs", regs_diff(), 0);

        txq.delete();
        push_word({MAGIC, 8'd2, 8'd5});
        push_word($urandom);
        push_word($urandom);
        for (int i = 0; i < 40 && rxq.size() > 0; i++) step();
        step();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < FW; w++) mdl[c][w] = '0;
        #1;
        check("mid_rst_regs", regs_diff(), 0);
        check("mid_rst_busy", busy, 0);
        for (int i = 0; i < TO + 10; i++) step();
        check("mid_rst_no_tx", txq.size(), 0);
        run_frame(8'd2, 8'd5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Parametrised successor to the DC-channel UART loader. Consumes bytes from a UART RX queue, assembles 32-bit big-endian words, and parses framed register images: header, payload, XOR checksum. A frame is committed atomically into one channel's register bank, or into all banks in broadcast mode, only if it passes every check. It answers each frame with a one-byte ACK or NAK on the UART TX queue, and sits between `uart` and the per-channel `dc` cores.

## Interface
- `NUM_CHANNELS`, 24: channel banks; legal range 1..255.
- `FRAME_WORDS`, 62: 32-bit registers per bank; legal range 1..255.
- `MAGIC`, 16'hD5C0: header sync value.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle gap, in cycles, inside a frame; must be ≥ 2.
- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: reset, synchronous and active-high.
- `i_rxq_data`, in, 8: head byte of the RX queue.
- `i_rxq_empty`, in, 1: the RX queue is empty.
- `o_deq_rxq`, out, 1: dequeues the head byte this cycle.
- `o_txq_data`, out, 8: response byte.
- `o_enq_txq`, out, 1: enqueues `o_txq_data` this cycle.
- `i_txq_full`, in, 1: the TX queue is full.
- `o_regs`, out, NUM_CHANNELS×FRAME_WORDS×32: register banks, packed as `[ch][word][31:0]`.
- `o_commit`, out, 1: one-cycle pulse when a frame is committed.
- `o_commit_chan`, out, 8: channel field of the committed frame; 0xFF means broadcast.
- `o_busy`, out, 1: a frame is in progress (state ≠ HDR, or a partial word is held).

## Operation
- **Byte intake.** `o_deq_rxq` = `!i_rxq_empty && state ∈ {HDR, PAYLOAD, CSUM}`.
  - Each dequeued byte shifts into a word buffer, MSB first.
  - A 2-bit byte counter wraps from 3 to 0 and marks a completed word.
- **Header word.** Layout: `[31:16]` magic, `[15:8]` channel, `[7:0]` length L.
  - Magic mismatch: discard the word silently and stay in HDR. This is word-level resync; no response is sent.
  - Channel must be `< NUM_CHANNELS` or 0xFF. Otherwise NAK 0x16, go to RESP.
  - Length must satisfy 1 ≤ L ≤ FRAME_WORDS. Otherwise NAK 0x17, go to RESP.
  - On a valid header: go to PAYLOAD, running XOR = header word, word index = 0.
- **PAYLOAD.** Word k is written into staging slot k and XORed into the running checksum.
  - The word index increments on each word.
  - After word L-1, go to CSUM.
- **CSUM.**
  - Received word == running XOR: go to COMMIT.
  - Otherwise: NAK 0x15, go to RESP. The banks are untouched.
- **COMMIT**, one cycle.
  - For the target bank, or every bank when the channel is 0xFF, words 0..L-1 are loaded from staging. Words L..FRAME_WORDS-1 keep their old values.
  - Assert `o_commit`, drive `o_commit_chan`, queue ACK 0x06, go to RESP.
- **RESP.** Hold the response byte until `!i_txq_full`. Then assert `o_enq_txq` for exactly one cycle and return to HDR.
- **Timeout.** A gap counter is cleared on every dequeued byte and counts while `o_busy` is asserted in HDR/PAYLOAD/CSUM. When it reaches TIMEOUT_CYCLES:
  - Discard the partial word and the frame.
  - Send NAK 0x18 via RESP.
- **Reset values.**
  - State HDR; `o_regs` all 0; staging 0; counters 0.
  - `o_deq_rxq` = 0 while `i_rst`; `o_enq_txq`, `o_commit`, `o_busy` = 0; `o_txq_data` = 0; `o_commit_chan` = 0.

## Timing
- Throughput: one byte per cycle while the RX queue is non-empty.
- The word is complete in the cycle the 4th byte is dequeued. The state/checksum decision registers at that clock edge, so the new state is valid the next cycle.
- `o_commit` is high in the cycle after the checksum byte's dequeue. `o_regs` shows the new values one cycle after `o_commit`.
- The earliest `o_enq_txq` is in the cycle after COMMIT. It stalls indefinitely while `i_txq_full`, and no RX bytes are dequeued during RESP.
- Reset asserted mid-frame or mid-RESP aborts with no response and clears the banks on the next edge.
- Only the low 8 bits of the word index and length matter, so FRAME_WORDS ≤ 255.
- The XOR is full 32-bit; there are no carries.

## Structure
- Package `uart_frame_pkg`:
  - state enum `frame_state_t` {HDR, PAYLOAD, CSUM, COMMIT, RESP};
  - response-code constants RSP_ACK, RSP_NAK_CSUM, RSP_NAK_CHAN, RSP_NAK_LEN, RSP_NAK_TIMEOUT;
  - BROADCAST_CHAN = 8'hFF.
- Sub-module `byte_word_packer`: byte shift register, byte counter, word-valid strobe, and clear input used by timeout and reset. The FSM, staging buffer, and banks stay in the top.

## Test plan
- **Good frame.** Header D5C0_0305, 5 payload words, correct XOR → `o_commit` = 1, `o_commit_chan` = 3, bank 3 words 0–4 updated, words 5–61 unchanged, TX byte 0x06.
- **Checksum error.** Same frame with checksum ^ 1 → no `o_commit`, all banks unchanged, TX 0x15, next valid frame accepted.
- **Bad header fields.** Channel 0x18 with NUM_CHANNELS = 24 → TX 0x16. Length 0 or 63 → TX 0x17. Garbage words before a valid header → silent resync, then 0x06.
- **Broadcast.** Header D5C0_FF3E with 62 words → all 24 banks identical, `o_commit_chan` = 0xFF.
- **Timeout and backpressure.**
  - Stop after 2 payload bytes → NAK 0x18 after TIMEOUT_CYCLES; the partial word is dropped.
  - `i_txq_full` held for 20 cycles in RESP → exactly one enqueue after release, and no RX dequeues while stalled.
- **Reset mid-frame.** Pulse `i_rst` during PAYLOAD → `o_regs` all 0, no TX byte, state HDR, next frame commits normally.
